// File: rtl/stim_ctrl_pkg.sv
// Shared FSM encoding and counter sizing for the stimulation vote controller.
package stim_ctrl_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        STIM    = 2'd1,
        REFRAC  = 2'd2
    } state_t;

    // Bits needed to hold 0..max_val; never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/feat_threshold_lane.sv
// One feature lane: holds the latest sample of the open window, flags it held, signed compare vs threshold.
// Latency: sample registered on strobe edge; compare is combinational on the stored sample.
// Backpressure: none; a second strobe in an open window overwrites and reports overrun.
module feat_threshold_lane #(
    parameter int DW = 40
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 accept,
    input  logic                 flush,
    input  logic                 din_valid,
    input  logic signed [DW-1:0] din,
    input  logic signed [DW-1:0] th,
    output logic                 held_next,
    output logic                 positive,
    output logic                 overrun
);

    logic signed [DW-1:0] sample_q;
    logic                 held_q;
    logic                 strobe;

    assign strobe    = accept & din_valid;
    assign held_next = held_q | strobe;
    assign overrun   = strobe & held_q;
    assign positive  = (sample_q >= th);

    always_ff @(posedge clk) begin
        if (rst) begin
            sample_q <= '0;
            held_q   <= 1'b0;
        end else begin
            if (strobe) begin
                sample_q <= din;
            end
            held_q <= flush ? 1'b0 : held_next;
        end
    end

endmodule

// File: rtl/stim_vote_controller.sv
// Closed-loop stimulation: K-of-N threshold vote per window, consecutive-vote trigger, pulse then lockout.
// Latency: vote registered one edge after window completion; stimulation rises on that same edge.
// Backpressure: none; strobes outside COLLECT or while disabled are dropped.
module stim_vote_controller
    import stim_ctrl_pkg::*;
#(
    parameter int N_FEAT     = 3,
    parameter int DW         = 40,
    parameter int VOTE_MIN   = 2,
    parameter int CONSEC     = 2,
    parameter int STIM_LEN   = 16,
    parameter int REFRAC_LEN = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [N_FEAT*DW-1:0]          din,
    input  logic [N_FEAT-1:0]             din_valid,
    input  logic [N_FEAT*DW-1:0]          th,
    output logic                          stimulation,
    output logic [$clog2(N_FEAT+1)-1:0]   vote_count,
    output logic                          vote_valid,
    output logic                          overrun,
    output logic [1:0]                    state
);

    localparam int CW   = $clog2(N_FEAT + 1);
    localparam int SW   = cnt_width(CONSEC);
    localparam int CNTW = cnt_width((STIM_LEN > REFRAC_LEN) ? STIM_LEN : REFRAC_LEN);
    localparam logic [CW-1:0] VOTE_MIN_C = CW'(VOTE_MIN);
    localparam logic [SW-1:0] CONSEC_C   = SW'(CONSEC);

    if (N_FEAT < 1) begin : g_chk_nfeat
        $error("N_FEAT must be >= 1");
    end
    if (VOTE_MIN < 1 || VOTE_MIN > N_FEAT) begin : g_chk_vote
        $error("VOTE_MIN must be in 1..N_FEAT");
    end
    if (CONSEC < 1) begin : g_chk_consec
        $error("CONSEC must be >= 1");
    end
    if (STIM_LEN < 1 || REFRAC_LEN < 0 || DW < 2) begin : g_chk_len
        $error("STIM_LEN >= 1, REFRAC_LEN >= 0 and DW >= 2 required");
    end

    state_t            state_q, state_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]     streak_q, streak_d;
    logic              eval_q;
    logic [CW-1:0]     vote_count_q;
    logic              vote_valid_q;
    logic              overrun_q;

    logic [N_FEAT-1:0] held_next, positive, lane_ovr;
    logic [CW-1:0]     pos_cnt;
    logic              vote, trigger, accept, flush, complete;

    for (genvar i = 0; i < N_FEAT; i++) begin : g_lane
        feat_threshold_lane #(.DW(DW)) u_lane (
            .clk       (clk),
            .rst       (rst),
            .accept    (accept),
            .flush     (flush),
            .din_valid (din_valid[i]),
            .din       (din[i*DW +: DW]),
            .th        (th[i*DW +: DW]),
            .held_next (held_next[i]),
            .positive  (positive[i]),
            .overrun   (lane_ovr[i])
        );
    end

    always_comb begin
        pos_cnt = '0;
        for (int i = 0; i < N_FEAT; i++) begin
            pos_cnt = pos_cnt + CW'(positive[i]);
        end
        vote    = (pos_cnt >= VOTE_MIN_C);
        // streak never rests at CONSEC, so reaching it means the previous value was CONSEC-1
        trigger = en && (state_q == COLLECT) && eval_q && vote && (streak_q >= CONSEC_C - 1'b1);
        // a window finishing on the trigger edge is dropped along with its flags
        accept   = en && (state_q == COLLECT) && !trigger;
        complete = accept && (&held_next);
        flush    = !accept || complete;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        streak_d = streak_q;
        if (!en) begin
            state_d  = COLLECT;
            cnt_d    = '0;
            streak_d = '0;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (trigger) begin
                        state_d  = STIM;
                        cnt_d    = CNTW'(STIM_LEN);
                        streak_d = '0;
                    end else if (eval_q) begin
                        streak_d = !vote ? '0 :
                                   (streak_q == CONSEC_C) ? streak_q : streak_q + 1'b1;
                    end
                end
                STIM: begin
                    streak_d = '0;
                    if (cnt_q <= CNTW'(1)) begin
                        state_d = (REFRAC_LEN == 0) ? COLLECT : REFRAC;
                        cnt_d   = CNTW'(REFRAC_LEN);
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                REFRAC: begin
                    streak_d = '0;
                    if (cnt_q <= CNTW'(1)) begin
                        state_d = COLLECT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_d  = COLLECT;
                    cnt_d    = '0;
                    streak_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= COLLECT;
            cnt_q        <= '0;
            streak_q     <= '0;
            eval_q       <= 1'b0;
            vote_count_q <= '0;
            vote_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            streak_q     <= streak_d;
            eval_q       <= complete;
            vote_valid_q <= eval_q && en;
            overrun_q    <= |lane_ovr;
            if (eval_q && en) begin
                vote_count_q <= pos_cnt;
            end
        end
    end

    assign stimulation = (state_q == STIM);
    assign state       = state_q;
    assign vote_count  = vote_count_q;
    assign vote_valid  = vote_valid_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_stim_vote_controller.sv
// Directed bench for stim_vote_controller with a vote-count scoreboard fed at window completion.
module tb_stim_vote_controller;

    localparam int N  = 3;
    localparam int DW = 40;
    localparam int CW = 2;

    logic              clk = 1'b0;
    logic              rst, en;
    logic [N*DW-1:0]   din, th;
    logic [N-1:0]      din_valid;
    logic              stimulation, vote_valid, overrun;
    logic [CW-1:0]     vote_count;
    logic [1:0]        state;

    int n_vec = 0;
    int n_err = 0;
    int exp_q[$];
    logic signed [DW-1:0] th_v [N];

    always #5 clk = ~clk;

    stim_vote_controller #(
        .N_FEAT(3), .DW(40), .VOTE_MIN(2), .CONSEC(2), .STIM_LEN(4), .REFRAC_LEN(8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .din         (din),
        .din_valid   (din_valid),
        .th          (th),
        .stimulation (stimulation),
        .vote_count  (vote_count),
        .vote_valid  (vote_valid),
        .overrun     (overrun),
        .state       (state)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_th();
        for (int i = 0; i < N; i++) th[i*DW +: DW] = th_v[i];
    endtask

    function automatic int exp_votes(input logic signed [DW-1:0] a, b, c);
        int n = 0;
        if (a >= th_v[0]) n++;
        if (b >= th_v[1]) n++;
        if (c >= th_v[2]) n++;
        return n;
    endfunction

    task automatic strobe_all(input logic signed [DW-1:0] a, b, c, input bit counted);
        din       = {c, b, a};
        din_valid = '1;
        if (counted) exp_q.push_back(exp_votes(a, b, c));
        tick();
        din_valid = '0;
    endtask

    task automatic strobe_lane(input int lane, input logic signed [DW-1:0] v);
        din[lane*DW +: DW] = v;
        din_valid = N'(1 << lane);
        tick();
        din_valid = '0;
    endtask

    // Every vote_valid pulse must match the oldest expected window result.
    always @(negedge clk) begin
        int e;
        if (vote_valid === 1'b1) begin
            n_vec++;
            assert (exp_q.size() > 0) else begin
                n_err++;
                $error("FAIL vote_valid_unexpected: observed pulse expected none");
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                assert (vote_count === CW'(e)) else begin
                    n_err++;
                    $error("FAIL vote_count: observed %0d expected %0d", vote_count, e);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; en = 1'b1; din = '0; din_valid = '0;
        for (int i = 0; i < N; i++) th_v[i] = 1000;
        apply_th();
        tick(); tick();
        check("rst_state", state, 0);
        check("rst_stim", stimulation, 0);
        check("rst_vote_count", vote_count, 0);
        check("rst_vote_valid", vote_valid, 0);
        check("rst_overrun", overrun, 0);
        rst = 1'b0;
        tick();

        // two positive windows back to back -> 4-cycle pulse, then 8-cycle lockout
        strobe_all(1500, 1000, 200, 1);
        strobe_all(1500, 1000, 200, 1);
        check("pre_trigger_state", state, 0);
        check("pre_trigger_stim", stimulation, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stim_high", stimulation, 1);
            check("stim_state", state, 1);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            check("refrac_stim_low", stimulation, 0);
            check("refrac_state", state, 2);
        end
        tick();
        check("back_to_collect", state, 0);

        // a negative window between positives clears the streak
        strobe_all(1500, 1000, 200, 1);
        strobe_all(1500, 999, -5000, 1);
        strobe_all(1500, 1000, 200, 1);
        tick();
        check("neg_window_no_trigger", state, 0);
        strobe_all(1500, 1000, 200, 1);
        tick();
        check("retrigger_after_two", state, 1);
        repeat (12) tick();
        check("collect_after_retrigger", state, 0);

        // staggered strobes: lane0 at t, lane2 at t+3, lane1 at t+5
        din = {40'sd200, 40'sd1000, 40'sd1500};
        strobe_lane(0, 1500);
        check("stagger_vv_t", vote_valid, 0);
        tick(); tick();
        strobe_lane(2, 200);
        check("stagger_vv_t3", vote_valid, 0);
        tick();
        exp_q.push_back(2);
        strobe_lane(1, 1000);
        check("stagger_vv_t5", vote_valid, 0);
        tick();
        check("stagger_vv_t6", vote_valid, 1);
        tick();

        // lane0 strobed twice; the second (999) must win -> single positive lane
        strobe_lane(0, 1500);
        check("no_overrun_first", overrun, 0);
        strobe_lane(0, 999);
        check("overrun_pulse", overrun, 1);
        tick();
        check("overrun_one_cycle", overrun, 0);
        din[1*DW +: DW] = 1000;
        din[2*DW +: DW] = 200;
        din_valid = 3'b110;
        exp_q.push_back(1);
        tick();
        din_valid = '0;
        check("overrun_complete_no_pulse", overrun, 0);
        tick(); tick();
        check("overrun_window_no_trigger", state, 0);

        // negative threshold on lane 0: equality counts positive
        th_v[0] = -100;
        apply_th();
        strobe_all(-100, 999, 200, 1);
        strobe_all(-101, 999, 200, 1);
        tick(); tick();
        th_v[0] = 1000;
        apply_th();
        check("neg_th_no_trigger", state, 0);

        // reset during the second stimulation cycle
        strobe_all(1500, 1000, 200, 1);
        strobe_all(1500, 1000, 200, 1);
        tick();
        check("rst_case_stim1", stimulation, 1);
        tick();
        rst = 1'b1;
        tick();
        check("mid_rst_stim", stimulation, 0);
        check("mid_rst_state", state, 0);
        check("mid_rst_vote_count", vote_count, 0);
        rst = 1'b0;
        tick();

        // en low during the second stimulation cycle keeps the last vote_count
        strobe_all(1500, 1000, 200, 1);
        strobe_all(1500, 1000, 200, 1);
        tick();
        check("en_case_stim1", stimulation, 1);
        tick();
        en = 1'b0;
        tick();
        check("en_abort_stim", stimulation, 0);
        check("en_abort_state", state, 0);
        check("en_abort_vote_count", vote_count, 2);
        en = 1'b1;
        tick();

        // strobes through STIM/REFRAC are ignored; the one on the trigger edge is dropped
        strobe_all(1500, 1000, 200, 1);
        strobe_all(1500, 1000, 200, 1);
        din = {40'sd200, 40'sd1000, 40'sd1500};
        din_valid = '1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("busy_no_overrun", overrun, 0);
            if (i > 0) check("busy_no_vote_valid", vote_valid, 0);
        end
        din_valid = '0;
        tick();
        check("busy_back_to_collect", state, 0);
        strobe_all(1500, 1000, 200, 1);
        tick();
        check("fresh_first_vote_no_trigger", state, 0);
        strobe_all(1500, 1000, 200, 1);
        tick();
        check("fresh_second_vote_trigger", state, 1);
        en = 1'b0;
        tick();
        en = 1'b1;
        tick(); tick();

        check("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
